// File: rtl/imm_chain_sequencer_pkg.sv
// Shared types, widths and encodings for the immediate chain sequencer.
package imm_chain_sequencer_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned IMM_W      = 12;
  localparam int unsigned TAG_W      = 4;
  localparam int unsigned MAX_CHUNKS = 3;
  localparam int unsigned CNT_W      = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_ZERO  = 2'b00;
  localparam mode_t MODE_SIGN  = 2'b01;
  localparam mode_t MODE_CHAIN = 2'b10;
  localparam mode_t MODE_LAST  = 2'b11;

endpackage

// File: rtl/imm_chain_sequencer_if.sv
// Decode-side beat channel and execute-side result channel.
interface imm_chain_sequencer_if;
  import imm_chain_sequencer_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [IMM_W-1:0]  in_imm;
  mode_t             in_mode;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;
  logic              out_err;

  modport master (
    output in_valid, in_imm, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_err
  );

  modport slave (
    input  in_valid, in_imm, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_err
  );
endinterface

// File: rtl/imm_chain_sequencer_zext.sv
// Zero-extends an immediate field to the full result width.
module imm_chain_sequencer_zext
  import imm_chain_sequencer_pkg::*;
(
  input  logic [IMM_W-1:0]  imm,
  output logic [DATA_W-1:0] ext_c
);

  // Pad the upper bits with zeros.
  assign ext_c = {{(DATA_W-IMM_W){1'b0}}, imm};

endmodule

// File: rtl/imm_chain_sequencer.sv
// Builds 32-bit constants from single or chained 12-bit immediate beats.
module imm_chain_sequencer
  import imm_chain_sequencer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  imm_chain_sequencer_if.slave bus
);

  state_t            state_q, state_nxt;
  logic [DATA_W-1:0] acc_q, acc_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic [TAG_W-1:0]  tag_q, tag_nxt;
  logic              err_q, err_nxt;

  logic              in_ready_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [TAG_W-1:0]  out_tag_q;
  logic              out_err_q;

  logic              beat;
  logic              load_out;
  logic [DATA_W-1:0] res_data;
  logic [TAG_W-1:0]  res_tag;
  logic              res_err;
  logic [DATA_W-1:0] zext;
  logic [DATA_W-1:0] sext;
  logic [DATA_W-1:0] shifted;
  logic              shift_err;
  logic [CNT_W-1:0]  cnt_inc;

  imm_chain_sequencer_zext u_zext (
    .imm   (bus.in_imm),
    .ext_c (zext)
  );

  assign beat    = bus.in_valid & in_ready_q;
  assign sext    = {{(DATA_W-IMM_W){bus.in_imm[IMM_W-1]}}, bus.in_imm};
  assign shifted = {acc_q[DATA_W-IMM_W-1:0], bus.in_imm};
  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : CNT_W'(cnt_q + 1'b1);
  // Bits shifted out, foreign tag, or one chunk too many.
  assign shift_err = (|acc_q[DATA_W-1:DATA_W-IMM_W])
                   | (bus.in_tag != tag_q)
                   | (cnt_q >= CNT_W'(MAX_CHUNKS));

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.out_err   = out_err_q;

  // State, chain accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      tag_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      acc_q       <= acc_nxt;
      cnt_q       <= cnt_nxt;
      tag_q       <= tag_nxt;
      err_q       <= err_nxt;
      in_ready_q  <= (state_nxt != ST_OUT);
      out_valid_q <= (state_nxt == ST_OUT);
      if (load_out) begin
        out_data_q <= res_data;
        out_tag_q  <= res_tag;
        out_err_q  <= res_err;
      end
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:  if (beat) state_nxt = (bus.in_mode == MODE_CHAIN) ? ST_ACCUM : ST_OUT;
      ST_ACCUM: if (beat && bus.in_mode != MODE_CHAIN) state_nxt = ST_OUT;
      ST_OUT:   if (out_valid_q && bus.out_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Per-beat datapath: chain update and result selection.
  always_comb begin
    acc_nxt  = acc_q;
    cnt_nxt  = cnt_q;
    tag_nxt  = tag_q;
    err_nxt  = err_q;
    load_out = 1'b0;
    res_data = '0;
    res_tag  = bus.in_tag;
    res_err  = 1'b0;
    if (beat) begin
      case (state_q)
        ST_IDLE: begin
          case (bus.in_mode)
            MODE_CHAIN: begin
              acc_nxt = zext;
              cnt_nxt = CNT_W'(1);
              tag_nxt = bus.in_tag;
              err_nxt = 1'b0;
            end
            MODE_SIGN: begin
              load_out = 1'b1;
              res_data = sext;
            end
            default: begin
              load_out = 1'b1;
              res_data = zext;
            end
          endcase
        end
        ST_ACCUM: begin
          case (bus.in_mode)
            MODE_CHAIN: begin
              acc_nxt = shifted;
              cnt_nxt = cnt_inc;
              err_nxt = err_q | shift_err;
            end
            MODE_LAST: begin
              load_out = 1'b1;
              res_data = shifted;
              res_tag  = tag_q;
              res_err  = err_q | shift_err;
              acc_nxt  = '0;
              cnt_nxt  = '0;
              err_nxt  = 1'b0;
            end
            default: begin
              // Open chain is abandoned; the single constant is flagged.
              load_out = 1'b1;
              res_data = (bus.in_mode == MODE_SIGN) ? sext : zext;
              res_err  = 1'b1;
              acc_nxt  = '0;
              cnt_nxt  = '0;
              err_nxt  = 1'b0;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_chain_sequencer.sv
// Directed self-checking bench for imm_chain_sequencer.
module tb_imm_chain_sequencer;
  import imm_chain_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_pass  = 0;

  imm_chain_sequencer_if bus ();

  imm_chain_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", name, obs, exp);
  endtask

  // Present one beat, waiting (bounded) for in_ready; drops in_valid after the accepting edge.
  task automatic send(input mode_t m, input logic [11:0] imm, input logic [3:0] tag);
    int n = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("send_timeout", 32'(n), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_mode  = m;
    bus.in_imm   = imm;
    bus.in_tag   = tag;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_mode  = MODE_SIGN;
    bus.in_imm   = 12'hFFF;
    bus.in_tag   = 4'hF;
  endtask

  // Result must be present one cycle after the last beat; then consume it.
  task automatic expect_out(input string name, input logic [31:0] d, input logic [3:0] t, input logic e);
    @(negedge clk);
    chk({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({name, "_data"},  bus.out_data, d);
    chk({name, "_tag"},   32'(bus.out_tag), 32'(t));
    chk({name, "_err"},   32'(bus.out_err), 32'(e));
    chk({name, "_noready"}, 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk({name, "_done"}, 32'(bus.out_valid), 32'd0);
    chk({name, "_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_mode   = MODE_ZERO;
    bus.in_imm    = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset values
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_data",  bus.out_data,       32'd0);
    chk("rst_out_tag",   32'(bus.out_tag),   32'd0);
    chk("rst_out_err",   32'(bus.out_err),   32'd0);

    // 1: ZERO single with out_ready held high
    bus.out_ready = 1'b1;
    send(MODE_ZERO, 12'hFFF, 4'd3);
    @(negedge clk);
    chk("t1_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_data",  bus.out_data, 32'h00000FFF);
    chk("t1_tag",   32'(bus.out_tag), 32'd3);
    chk("t1_err",   32'(bus.out_err), 32'd0);
    chk("t1_noready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk("t1_done",  32'(bus.out_valid), 32'd0);
    chk("t1_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;

    // 2: SIGN single held under backpressure for 5 cycles
    send(MODE_SIGN, 12'h800, 4'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_valid_hold", 32'(bus.out_valid), 32'd1);
      chk("t2_data_hold",  bus.out_data, 32'hFFFFF800);
      chk("t2_tag_hold",   32'(bus.out_tag), 32'd1);
      chk("t2_noready",    32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t2_noready_on_consume", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("t2_done", 32'(bus.out_valid), 32'd0);

    // SIGN of a positive field stays positive
    send(MODE_SIGN, 12'h7FF, 4'd2);
    expect_out("sign_pos", 32'h000007FF, 4'd2, 1'b0);

    // CHAIN_LAST with no chain open is a plain zero-extend
    send(MODE_LAST, 12'hABC, 4'd4);
    expect_out("last_alone", 32'h00000ABC, 4'd4, 1'b0);

    // 3: three-beat chain
    send(MODE_CHAIN, 12'h012, 4'd7);
    send(MODE_CHAIN, 12'h345, 4'd7);
    send(MODE_LAST,  12'h678, 4'd7);
    expect_out("t3", 32'h12345678, 4'd7, 1'b0);

    // 4: overflow and too many chunks; acc keeps shifting regardless
    send(MODE_CHAIN, 12'hABC, 4'd8);
    send(MODE_CHAIN, 12'hDEF, 4'd8);
    send(MODE_CHAIN, 12'h123, 4'd8);
    send(MODE_LAST,  12'h456, 4'd8);
    expect_out("t4", 32'hEF123456, 4'd8, 1'b1);

    // 5a: tag mismatch; the chain's latched tag is reported
    send(MODE_CHAIN, 12'h001, 4'd2);
    send(MODE_LAST,  12'h002, 4'd5);
    expect_out("t5_tag", 32'h00001002, 4'd2, 1'b1);

    // 5b: chain abandoned by a ZERO single
    send(MODE_CHAIN, 12'h0FF, 4'd1);
    send(MODE_ZERO,  12'h001, 4'd6);
    expect_out("t5_abandon", 32'h00000001, 4'd6, 1'b1);

    // Error flag does not leak into the next clean constant
    send(MODE_ZERO, 12'h055, 4'd3);
    expect_out("after_err", 32'h00000055, 4'd3, 1'b0);

    // 6: reset mid-chain
    send(MODE_CHAIN, 12'h111, 4'd9);
    send(MODE_CHAIN, 12'h222, 4'd9);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_ready", 32'(bus.in_ready), 32'd1);
    send(MODE_ZERO, 12'h00A, 4'd9);
    expect_out("t6_after", 32'h0000000A, 4'd9, 1'b0);

    // Reset while a result is pending
    send(MODE_SIGN, 12'hF00, 4'd5);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid2", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data2",  bus.out_data, 32'd0);
    chk("rst_out_tag2",   32'(bus.out_tag), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
